hv_pwm_intb_encode_sched: RTL

//  HV-side scheduler for the shared single-wire PWM INTB link to the LV die.

---
 rtl/hv_pwm_intb_encode_sched.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/hv_pwm_intb_encode_sched.sv
// hv_pwm_intb_encode_sched: encodes HV interrupt level changes as PWM pulse-train frames on the INTB wire
module hv_pwm_intb_encode_sched #(
    parameter int PULSE_CYC   = 5,
    parameter int GAP_CYC     = 2,
    parameter int GUARD_CYC   = 12,
    parameter int REFRESH_CYC = 1024
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_en,
    input  logic i_intb_n,
    output logic o_hv_pwm_intb_n,
    output logic o_busy,
    output logic o_sent_intb_n,
    output logic o_frame_done
);
    localparam int MAXC = (PULSE_CYC > GAP_CYC)
        ? ((PULSE_CYC > GUARD_CYC) ? PULSE_CYC : GUARD_CYC)
        : ((GAP_CYC > GUARD_CYC) ? GAP_CYC : GUARD_CYC);
    localparam int CW = $clog2(MAXC + 1);
    localparam int RW = (REFRESH_CYC > 0) ? $clog2(REFRESH_CYC + 1) : 1;
    localparam logic [RW-1:0] RMAX = RW'((REFRESH_CYC > 0) ? REFRESH_CYC - 1 : 0);

    typedef enum logic [1:0] {IDLE, PULSE, GAP, GUARD} state_t;

    state_t state, state_nx;
    logic [CW-1:0] cyc_cnt, cyc_nx;
    logic [2:0] pulse_idx, pulse_nx;
    logic [RW-1:0] ref_cnt, ref_nx;
    logic code, code_nx, sent_nx, resend, resend_nx, valid, valid_nx, done_nx, init;
    logic change, refresh, trig, last_pulse;

    // frame trigger terms; init holds off triggers for the single cycle before the post-reset guard
    always_comb begin
        change     = (i_intb_n != o_sent_intb_n) || resend;
        refresh    = (REFRESH_CYC != 0) && (ref_cnt == RMAX);
        trig       = (state == IDLE) && !init && i_en && (change || refresh);
        last_pulse = pulse_idx == (code ? 3'd3 : 3'd0);
    end

    // next-state and counter logic; valid marks a frame that has not been aborted
    always_comb begin
        state_nx  = state;
        cyc_nx    = cyc_cnt;
        pulse_nx  = pulse_idx;
        code_nx   = code;
        sent_nx   = o_sent_intb_n;
        resend_nx = resend;
        valid_nx  = valid;
        done_nx   = 1'b0;
        ref_nx    = !i_en ? '0
                  : (state == IDLE && !init && ref_cnt != RMAX) ? ref_cnt + 1'b1 : ref_cnt;
        case (state)
            IDLE: begin
                if (init) begin
                    state_nx = GUARD;
                    cyc_nx   = '0;
                end else if (trig) begin
                    state_nx  = PULSE;
                    cyc_nx    = '0;
                    pulse_nx  = '0;
                    code_nx   = i_intb_n;
                    sent_nx   = i_intb_n;
                    resend_nx = 1'b0;
                    valid_nx  = 1'b1;
                    ref_nx    = '0;
                end
            end
            PULSE: begin
                if (!i_en) begin
                    state_nx  = GUARD;
                    cyc_nx    = '0;
                    resend_nx = 1'b1;
                    valid_nx  = 1'b0;
                end else if (cyc_cnt == CW'(PULSE_CYC - 1)) begin
                    state_nx = last_pulse ? GUARD : GAP;
                    cyc_nx   = '0;
                    pulse_nx = pulse_idx + 3'd1;
                end else begin
                    cyc_nx = cyc_cnt + 1'b1;
                end
            end
            GAP: begin
                if (!i_en) begin
                    state_nx  = GUARD;
                    cyc_nx    = '0;
                    resend_nx = 1'b1;
                    valid_nx  = 1'b0;
                end else if (cyc_cnt == CW'(GAP_CYC - 1)) begin
                    state_nx = PULSE;
                    cyc_nx   = '0;
                end else begin
                    cyc_nx = cyc_cnt + 1'b1;
                end
            end
            GUARD: begin
                if (cyc_cnt == CW'(GUARD_CYC - 1)) begin
                    state_nx = IDLE;
                    cyc_nx   = '0;
                    done_nx  = valid;
                    valid_nx = 1'b0;
                end else begin
                    cyc_nx = cyc_cnt + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // state and output registers; the line is high exactly while the FSM sits in PULSE
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state           <= IDLE;
            init            <= 1'b1;
            cyc_cnt         <= '0;
            pulse_idx       <= '0;
            ref_cnt         <= '0;
            code            <= 1'b0;
            resend          <= 1'b0;
            valid           <= 1'b0;
            o_sent_intb_n   <= 1'b1;
            o_frame_done    <= 1'b0;
            o_hv_pwm_intb_n <= 1'b0;
        end else begin
            state           <= state_nx;
            init            <= 1'b0;
            cyc_cnt         <= cyc_nx;
            pulse_idx       <= pulse_nx;
            ref_cnt         <= ref_nx;
            code            <= code_nx;
            resend          <= resend_nx;
            valid           <= valid_nx;
            o_sent_intb_n   <= sent_nx;
            o_frame_done    <= done_nx;
            o_hv_pwm_intb_n <= (state_nx == PULSE);
        end
    end

    assign o_busy = (state != IDLE);
endmodule
